// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - allocation, writeback, flush and commit signals of the reorder buffer
interface rob_commit_unit_if #(
    parameter int ROB_DEPTH_BITS = 4,
    parameter int PHY_BITS       = 6,
    parameter int LOG_BITS       = 5
);
    logic                      alloc_valid;
    logic                      alloc_uses_rw;
    logic [PHY_BITS-1:0]       alloc_rw_phy;
    logic [LOG_BITS-1:0]       alloc_rw_log;
    logic [ROB_DEPTH_BITS-1:0] alloc_tag;
    logic                      alloc_ready;
    logic                      wb_valid;
    logic [ROB_DEPTH_BITS-1:0] wb_tag;
    logic                      flush;
    logic                      commit_valid;
    logic                      reg_wr_en;
    logic [PHY_BITS-1:0]       reg_wr_addr;
    logic [LOG_BITS-1:0]       reg_wr_log;
    logic [ROB_DEPTH_BITS:0]   count;
    logic                      empty;

    modport master (
        output alloc_valid, alloc_uses_rw, alloc_rw_phy, alloc_rw_log,
        output wb_valid, wb_tag, flush,
        input  alloc_tag, alloc_ready, commit_valid, reg_wr_en,
        input  reg_wr_addr, reg_wr_log, count, empty
    );

    modport slave (
        input  alloc_valid, alloc_uses_rw, alloc_rw_phy, alloc_rw_log,
        input  wb_valid, wb_tag, flush,
        output alloc_tag, alloc_ready, commit_valid, reg_wr_en,
        output reg_wr_addr, reg_wr_log, count, empty
    );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - reorder buffer issuing tags and retiring in order with physical-register commit
module rob_commit_unit #(
    parameter int ROB_DEPTH      = 16,
    parameter int ROB_DEPTH_BITS = 4,
    parameter int PHY_BITS       = 6,
    parameter int LOG_BITS       = 5
) (
    input  logic                clk,
    input  logic                rst,
    rob_commit_unit_if.slave    rob
);
    localparam int PTR_W = ROB_DEPTH_BITS + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(ROB_DEPTH);

    logic [PTR_W-1:0]          head_q;
    logic [PTR_W-1:0]          tail_q;
    logic [PTR_W-1:0]          count_w;
    logic [ROB_DEPTH_BITS-1:0] head_idx;
    logic [ROB_DEPTH_BITS-1:0] tail_idx;

    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;
    logic [ROB_DEPTH-1:0]      uses_rw_q;
    logic [PHY_BITS-1:0]       phy_q [ROB_DEPTH];
    logic [LOG_BITS-1:0]       log_q [ROB_DEPTH];

    logic                      commit_valid_q;
    logic                      reg_wr_en_q;
    logic [PHY_BITS-1:0]       reg_wr_addr_q;
    logic [LOG_BITS-1:0]       reg_wr_log_q;

    logic                      full;
    logic                      do_alloc;
    logic                      do_commit;
    logic                      do_wb;

    assign head_idx  = head_q[ROB_DEPTH_BITS-1:0];
    assign tail_idx  = tail_q[ROB_DEPTH_BITS-1:0];
    assign count_w   = tail_q - head_q;
    assign full      = (count_w == FULL_CNT);

    assign do_alloc  = rob.alloc_valid && !full;
    assign do_commit = valid_q[head_idx] && done_q[head_idx];
    // An entry retiring this edge must not have its done bit re-raised after invalidation.
    assign do_wb     = rob.wb_valid && valid_q[rob.wb_tag] &&
                       !(do_commit && (rob.wb_tag == head_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            commit_valid_q <= 1'b0;
            reg_wr_en_q    <= 1'b0;
            reg_wr_addr_q  <= '0;
            reg_wr_log_q   <= '0;
        end else if (rob.flush) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            commit_valid_q <= 1'b0;
            reg_wr_en_q    <= 1'b0;
        end else begin
            if (do_commit) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + PTR_ONE;
                commit_valid_q    <= 1'b1;
                reg_wr_en_q       <= uses_rw_q[head_idx] && (log_q[head_idx] != '0);
                reg_wr_addr_q     <= phy_q[head_idx];
                reg_wr_log_q      <= log_q[head_idx];
            end else begin
                commit_valid_q    <= 1'b0;
                reg_wr_en_q       <= 1'b0;
            end
            if (do_wb) begin
                done_q[rob.wb_tag] <= 1'b1;
            end
            // Allocation is applied last so it wins over a same-entry writeback.
            if (do_alloc) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + PTR_ONE;
            end
        end
    end

    // Payload is only read while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_alloc && !rob.flush) begin
            uses_rw_q[tail_idx] <= rob.alloc_uses_rw;
            phy_q[tail_idx]     <= rob.alloc_rw_phy;
            log_q[tail_idx]     <= rob.alloc_rw_log;
        end
    end

    assign rob.alloc_tag    = tail_idx;
    assign rob.alloc_ready  = !full;
    assign rob.count        = count_w;
    assign rob.empty        = (count_w == '0);
    assign rob.commit_valid = commit_valid_q;
    assign rob.reg_wr_en    = reg_wr_en_q;
    assign rob.reg_wr_addr  = reg_wr_addr_q;
    assign rob.reg_wr_log   = reg_wr_log_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - directed self-checking bench for rob_commit_unit
module tb_rob_commit_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rob_commit_unit_if #(.ROB_DEPTH_BITS(4), .PHY_BITS(6), .LOG_BITS(5)) rob_bus ();

    rob_commit_unit #(
        .ROB_DEPTH(16), .ROB_DEPTH_BITS(4), .PHY_BITS(6), .LOG_BITS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rob(rob_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_bus.alloc_valid   = 1'b0;
        rob_bus.alloc_uses_rw = 1'b0;
        rob_bus.alloc_rw_phy  = '0;
        rob_bus.alloc_rw_log  = '0;
        rob_bus.wb_valid      = 1'b0;
        rob_bus.wb_tag        = '0;
        rob_bus.flush         = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        rob_bus.flush = 1'b1;
        step();
        rob_bus.flush = 1'b0;
    endtask

    task automatic set_alloc(input logic uses, input logic [5:0] phy, input logic [4:0] lg);
        rob_bus.alloc_valid   = 1'b1;
        rob_bus.alloc_uses_rw = uses;
        rob_bus.alloc_rw_phy  = phy;
        rob_bus.alloc_rw_log  = lg;
    endtask

    task automatic set_wb(input logic [3:0] tag);
        rob_bus.wb_valid = 1'b1;
        rob_bus.wb_tag   = tag;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (rob_bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rob_bus.count); end
        n_checks++; if (rob_bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", rob_bus.empty); end
        n_checks++; if (rob_bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rob_bus.alloc_ready); end
        n_checks++; if (rob_bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", rob_bus.alloc_tag); end
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", rob_bus.reg_wr_en); end
        n_checks++; if (rob_bus.reg_wr_addr !== 6'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", rob_bus.reg_wr_addr); end
        n_checks++; if (rob_bus.reg_wr_log !== 5'd0) begin n_fail++; $display("FAIL reset_wr_log: got %0d expected 0", rob_bus.reg_wr_log); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_in_order();
        logic [5:0] exp_phy [3];
        exp_phy[0] = 6'd32; exp_phy[1] = 6'd33; exp_phy[2] = 6'd34;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rob_bus.alloc_tag !== 4'(i)) begin n_fail++; $display("FAIL order_tag%0d: got %0d expected %0d", i, rob_bus.alloc_tag, i); end
            set_alloc(1'b1, exp_phy[i], 5'(i + 1));
            step();
        end
        idle();
        n_checks++; if (rob_bus.alloc_tag !== 4'd3) begin n_fail++; $display("FAIL order_tag3: got %0d expected 3", rob_bus.alloc_tag); end
        set_wb(4'd2);
        step();
        idle();
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_commit: got %b expected 0", rob_bus.commit_valid); end
        set_wb(4'd0);
        step();
        idle();
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_no_bypass: got %b expected 0", rob_bus.commit_valid); end
        set_wb(4'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL order_commit%0d_valid: got %b expected 1", i, rob_bus.commit_valid); end
            n_checks++; if (rob_bus.reg_wr_addr !== exp_phy[i]) begin n_fail++; $display("FAIL order_commit%0d_phy: got %0d expected %0d", i, rob_bus.reg_wr_addr, exp_phy[i]); end
            n_checks++; if (rob_bus.reg_wr_log !== 5'(i + 1)) begin n_fail++; $display("FAIL order_commit%0d_log: got %0d expected %0d", i, rob_bus.reg_wr_log, i + 1); end
            n_checks++; if (rob_bus.reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL order_commit%0d_wr_en: got %b expected 1", i, rob_bus.reg_wr_en); end
        end
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_drained_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.empty !== 1'b1) begin n_fail++; $display("FAIL order_drained_empty: got %b expected 1", rob_bus.empty); end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, 6'(10 + i), 5'(i + 1));
            step();
        end
        idle();
        n_checks++; if (rob_bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", rob_bus.count); end
        n_checks++; if (rob_bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", rob_bus.alloc_ready); end
        n_checks++; if (rob_bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL full_tag: got %0d expected 0", rob_bus.alloc_tag); end
        set_alloc(1'b1, 6'd63, 5'd31);
        step();
        idle();
        n_checks++; if (rob_bus.count !== 5'd16) begin n_fail++; $display("FAIL full_17th_count: got %0d expected 16", rob_bus.count); end
        n_checks++; if (rob_bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL full_17th_tag: got %0d expected 0", rob_bus.alloc_tag); end
        set_wb(4'd0);
        step();
        idle();
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL full_commit_valid: got %b expected 1", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.reg_wr_addr !== 6'd10) begin n_fail++; $display("FAIL full_commit_phy: got %0d expected 10", rob_bus.reg_wr_addr); end
        n_checks++; if (rob_bus.count !== 5'd15) begin n_fail++; $display("FAIL full_count_after: got %0d expected 15", rob_bus.count); end
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL full_single_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after: got %b expected 1", rob_bus.alloc_ready); end
    endtask

    task automatic test_back_to_back();
        do_flush();
        for (int k = 0; k < 42; k++) begin
            idle();
            if (k < 40) begin
                n_checks++; if (rob_bus.alloc_tag !== 4'(k % 16)) begin n_fail++; $display("FAIL b2b_tag k=%0d: got %0d expected %0d", k, rob_bus.alloc_tag, k % 16); end
                set_alloc(1'b1, 6'((k * 7 + 5) % 64), 5'(k % 31 + 1));
            end
            if (k >= 1 && k <= 40) set_wb(4'((k - 1) % 16));
            step();
            if (k >= 1 && k <= 39) begin
                n_checks++; if (rob_bus.count !== 5'd2) begin n_fail++; $display("FAIL b2b_count k=%0d: got %0d expected 2", k, rob_bus.count); end
            end
            if (k >= 2) begin
                n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_commit k=%0d: got %b expected 1", k, rob_bus.commit_valid); end
                n_checks++; if (rob_bus.reg_wr_addr !== 6'(((k - 2) * 7 + 5) % 64)) begin n_fail++; $display("FAIL b2b_phy k=%0d: got %0d expected %0d", k, rob_bus.reg_wr_addr, ((k - 2) * 7 + 5) % 64); end
            end
        end
        idle();
        step();
        n_checks++; if (rob_bus.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", rob_bus.empty); end
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", rob_bus.commit_valid); end
    endtask

    task automatic test_no_regwr();
        do_flush();
        set_alloc(1'b0, 6'd40, 5'd5);
        step();
        set_alloc(1'b1, 6'd41, 5'd0);
        step();
        idle();
        set_wb(4'd0);
        step();
        idle();
        set_wb(4'd1);
        step();
        idle();
        n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL norw_a_valid: got %b expected 1", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL norw_a_wr_en: got %b expected 0", rob_bus.reg_wr_en); end
        n_checks++; if (rob_bus.reg_wr_addr !== 6'd40) begin n_fail++; $display("FAIL norw_a_phy: got %0d expected 40", rob_bus.reg_wr_addr); end
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL norw_b_valid: got %b expected 1", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL norw_b_wr_en: got %b expected 0", rob_bus.reg_wr_en); end
        n_checks++; if (rob_bus.reg_wr_addr !== 6'd41) begin n_fail++; $display("FAIL norw_b_phy: got %0d expected 41", rob_bus.reg_wr_addr); end
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 6'(20 + i), 5'(i + 1));
            step();
        end
        idle();
        set_wb(4'd0);
        step();
        idle();
        set_wb(4'd1);
        set_alloc(1'b1, 6'd50, 5'd9);
        rob_bus.flush = 1'b1;
        step();
        idle();
        n_checks++; if (rob_bus.count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", rob_bus.count); end
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL flush_tag: got %0d expected 0", rob_bus.alloc_tag); end
        n_checks++; if (rob_bus.empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", rob_bus.empty); end
        set_wb(4'd3);
        step();
        idle();
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL stale_wb_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.count !== 5'd0) begin n_fail++; $display("FAIL stale_wb_count: got %0d expected 0", rob_bus.count); end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < 8; i++) begin
            set_alloc(1'b1, 6'(1 + i), 5'(i + 1));
            step();
        end
        idle();
        set_wb(4'd0);
        step();
        idle();
        step();
        n_checks++; if (rob_bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_commit: got %b expected 1", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.count !== 5'd7) begin n_fail++; $display("FAIL arst_pre_count: got %0d expected 7", rob_bus.count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (rob_bus.count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", rob_bus.count); end
        n_checks++; if (rob_bus.empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b expected 1", rob_bus.empty); end
        n_checks++; if (rob_bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", rob_bus.alloc_ready); end
        n_checks++; if (rob_bus.alloc_tag !== 4'd0) begin n_fail++; $display("FAIL arst_tag: got %0d expected 0", rob_bus.alloc_tag); end
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_commit: got %b expected 0", rob_bus.commit_valid); end
        n_checks++; if (rob_bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL arst_wr_en: got %b expected 0", rob_bus.reg_wr_en); end
        n_checks++; if (rob_bus.reg_wr_addr !== 6'd0) begin n_fail++; $display("FAIL arst_wr_addr: got %0d expected 0", rob_bus.reg_wr_addr); end
        n_checks++; if (rob_bus.reg_wr_log !== 5'd0) begin n_fail++; $display("FAIL arst_wr_log: got %0d expected 0", rob_bus.reg_wr_log); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if (rob_bus.count !== 5'd0) begin n_fail++; $display("FAIL arst_post_count: got %0d expected 0", rob_bus.count); end
        n_checks++; if (rob_bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL arst_post_commit: got %b expected 0", rob_bus.commit_valid); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_full();
        test_back_to_back();
        test_no_regwr();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer that pairs with register rename.
- Issues ROB tags to renamed instructions and records their completions.
- Retires instructions strictly in program order.
- On each retirement it drives the physical-register commit write that frees and readies registers in the rename block: this is the producer end of the rob_reg_wr / rob_status path.

Parameters:
- ROB_DEPTH, 16, number of entries (power of two).
- ROB_DEPTH_BITS, 4, log2(ROB_DEPTH); width of a tag.
- PHY_BITS, 6, physical register index width (64 physical regs).
- LOG_BITS, 5, logical register index width (32 logical regs).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  renamed instruction requests an entry.
- alloc_uses_rw  in  1  instruction writes a destination register.
- alloc_rw_phy  in  PHY_BITS  physical destination assigned by rename.
- alloc_rw_log  in  LOG_BITS  logical destination.
- alloc_tag  out  ROB_DEPTH_BITS  tag the next allocation receives (tail index).
- alloc_ready  out  1  ~full.
- wb_valid  in  1  execution completion strobe.
- wb_tag  in  ROB_DEPTH_BITS  tag of completing instruction.
- flush  in  1  branch mispredict; discard all entries.
- commit_valid  out  1  one instruction retired this cycle.
- reg_wr_en  out  1  retired instruction had uses_rw and alloc_rw_log != 0.
- reg_wr_addr  out  PHY_BITS  physical register being committed.
- reg_wr_log  out  LOG_BITS  logical register being committed.
- count  out  ROB_DEPTH_BITS+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Storage and pointers:
  - Circular buffer with per-entry fields valid, done, uses_rw, phy, log.
  - head and tail are ROB_DEPTH_BITS+1 wide; the extra MSB is a wrap bit.
  - count = tail - head, modulo 2^(ROB_DEPTH_BITS+1).
  - full = (count == ROB_DEPTH); empty = (count == 0).
  - alloc_tag = tail[ROB_DEPTH_BITS-1:0]; it is combinational from registered state.
- Allocation:
  - Occurs when alloc_valid && alloc_ready.
  - Writes the tail entry with valid=1, done=0 and the field values, then tail increments.
  - With alloc_valid while full: no state change; the upstream stage stalls.
- Writeback:
  - When wb_valid is high and the entry at wb_tag has valid=1, that entry's done is set to 1.
  - Writeback to an invalid entry is ignored.
  - If writeback targets the entry being allocated in the same cycle, allocation wins and done=0.
- Commit:
  - At most one retirement per cycle.
  - If the head entry has valid && done at a rising edge, the entry is invalidated and head increments.
  - On the same edge the registered outputs load: commit_valid=1, reg_wr_en = uses_rw && (log != 0), reg_wr_addr = phy, reg_wr_log = log.
  - Otherwise commit_valid and reg_wr_en load 0. reg_wr_addr and reg_wr_log hold their values.
  - There is no done bypass: a writeback in cycle N makes the instruction committable at edge N+1, so commit outputs are high in cycle N+2 at the earliest.
- Simultaneous events:
  - Allocate and commit in the same cycle are both performed; count is unchanged.
  - full and alloc_ready come from pre-edge state, so a commit does not unblock an allocation in the same cycle.
- Wrap-around: pointers wrap naturally. After 2*ROB_DEPTH allocations the wrap bit has toggled twice. A full buffer with head == tail index is distinguished by the wrap bit.
- Flush (synchronous, highest priority):
  - Clears every valid and done bit and sets head=tail=0.
  - Loads commit_valid=0 and reg_wr_en=0.
  - Allocation, writeback and commit requests in the flush cycle are dropped.
  - After flush, alloc_tag=0.
- Reset (rst high, asynchronous, any time including mid-operation):
  - All entries invalid; head=tail=0; count=0; empty=1; alloc_ready=1; alloc_tag=0.
  - commit_valid=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_log=0.

Test Plan:
- Reset, then allocate 3 (phy 32,33,34; log 1,2,3); write back tags 2,0,1 in that order.
  - Required: commits in order 32,33,34 on consecutive cycles.
  - Required: the first commit appears 2 cycles after the wb of tag 0.
  - Required: alloc_tag goes 0,1,2,3.
- Allocate 16 without writeback.
  - Required: count=16, alloc_ready=0; a 17th alloc_valid leaves alloc_tag=0 and state unchanged.
  - Then write back tag 0. Required: one commit, with count=15 afterwards.
- Steady state with alloc, wb and commit every cycle over 40 instructions.
  - Required: count constant, tags wrap 15→0, commits strictly in order with correct phy values.
- Allocate with uses_rw=0, and separately with log=0.
  - Required: commit_valid=1, reg_wr_en=0 in both cases.
- Allocate 5, write back 2, assert flush in the same cycle as a new alloc.
  - Required: count=0, no commit the next cycle, alloc_tag=0, the new alloc is dropped.
  - Then stale wb_tag=3. Required: ignored.
- Assert rst asynchronously mid-stream with 8 entries live.
  - Required: outputs reach their reset values immediately, without waiting for a clock edge.
